// File: rtl/uart_rx_controller.sv
// UART receive sequencer: gates the receiver, captures each finished frame into a
// first-word-fall-through FIFO and raises overflow / idle-timeout / level interrupts.
module uart_rx_controller #(
  parameter int FIFO_DEPTH    = 8,
  parameter int IRQ_LEVEL     = 4,
  parameter int TIMEOUT_TICKS = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          baud_in,
  input  logic                          rx_busy,
  input  logic [7:0]                    rx_byte,
  output logic                          rx_reset,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          timeout,
  output logic                          irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_TICKS) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] IRQ_L   = LW'(IRQ_LEVEL);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    IDLE      = 2'd1,
    RECEIVING = 2'd2,
    CAPTURE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            rx_busy_q, baud_q;
  logic            rx_reset_q, rx_reset_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            empty_q, empty_d, full_q, full_d;
  logic            overflow_q, overflow_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            irq_q, irq_d;

  logic            push_req, pop, wr, drop, baud_rise, to_set;

  // FSM next-state: disable overrides every state and discards any partial frame
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED:  state_d = IDLE;
        IDLE:      if (rx_busy) state_d = RECEIVING; else state_d = IDLE;
        RECEIVING: if (rx_busy_q && !rx_busy) state_d = CAPTURE; else state_d = RECEIVING;
        CAPTURE:   state_d = IDLE;
        default:   state_d = DISABLED;
      endcase
    end
    rx_reset_d = (state_d == DISABLED);
  end

  // FIFO datapath; a full FIFO still accepts a byte when the head is popped in the same cycle
  always_comb begin
    push_req = (state_q == CAPTURE) && enable;
    pop      = rd_en && (level_q != {LW{1'b0}});
    wr       = push_req && ((level_q != DEPTH_L) || pop);
    drop     = push_req && (level_q == DEPTH_L) && !pop;
    mem_d    = mem_q;
    if (wr) begin
      mem_d[tail_q] = rx_byte;
      tail_d        = tail_q + AW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop) begin
      head_d = head_q + AW'(1);
    end else begin
      head_d = head_q;
    end
    level_d = level_q + LW'(wr) - LW'(pop);
    empty_d = (level_d == {LW{1'b0}});
    full_d  = (level_d == DEPTH_L);
    // New head may be the byte being written this very cycle
    if (wr && (tail_q == head_d)) begin
      rd_data_d = rx_byte;
    end else begin
      rd_data_d = mem_q[head_d];
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Idle-timeout counter and sticky flag
  always_comb begin
    baud_rise = baud_in && !baud_q;
    to_set    = 1'b0;
    if (wr || (level_q == {LW{1'b0}}) || ((state_q == IDLE) && (state_d != IDLE))) begin
      cnt_d = {CW{1'b0}};
    end else if ((state_q == IDLE) && !timeout_q && baud_rise) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = cnt_q;
        to_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    if (to_set && (level_d != {LW{1'b0}})) begin
      timeout_d = 1'b1;
    end else if (wr || (level_d == {LW{1'b0}})) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
    irq_d = (level_q >= IRQ_L) || overflow_q || timeout_q;
  end

  // State, FIFO and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DISABLED;
      rx_reset_q <= 1'b1;
      rx_busy_q  <= 1'b0;
      baud_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      head_q     <= {AW{1'b0}};
      tail_q     <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      rd_data_q  <= 8'h00;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_reset_q <= rx_reset_d;
      rx_busy_q  <= rx_busy;
      baud_q     <= baud_in;
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign rx_reset = rx_reset_q;
  assign rd_data  = rd_data_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;
  assign irq      = irq_q;

endmodule
